// File: rtl/alu_element.sv
// rtl/alu_element.sv - registered WIDTH-bit ripple-carry ALU slice with 3-bit op select
module alu_element #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             y,
    input  logic             w,
    input  logic             ci,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             co,
    output logic [WIDTH-1:0] s
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOT  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_INC  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    op_e              op;
    logic             arith;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s_d;
    logic             co_d;
    logic [WIDTH-1:0] s_q;
    logic             co_q;

    assign op = op_e'({x, y, w});

    // Operand conditioning: SUB is ADD with b inverted; only arithmetic ops see ci.
    always_comb begin
        arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC);
        b_eff = (op == OP_SUB) ? ~b : b;
    end

    // Per-bit cell chain; carry ripples from bit 0 upward and stays 0 for logic ops.
    always_comb begin
        carry    = '0;
        s_d      = '0;
        carry[0] = arith ? ci : 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (op)
                OP_AND: s_d[i] = a[i] & b[i];
                OP_OR:  s_d[i] = a[i] | b[i];
                OP_XOR: s_d[i] = a[i] ^ b[i];
                OP_NOT: s_d[i] = ~b[i];
                OP_ADD, OP_SUB: begin
                    s_d[i]       = a[i] ^ b_eff[i] ^ carry[i];
                    carry[i + 1] = (a[i] & b_eff[i]) | (a[i] & carry[i]) | (b_eff[i] & carry[i]);
                end
                OP_INC: begin
                    s_d[i]       = a[i] ^ carry[i];
                    carry[i + 1] = a[i] & carry[i];
                end
                default: s_d[i] = 1'b0;
            endcase
        end
        co_d = carry[WIDTH];
    end

    // Output registers; reset clears the result and drops whatever was in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_q  <= '0;
            co_q <= 1'b0;
        end else begin
            s_q  <= s_d;
            co_q <= co_d;
        end
    end

    assign s  = s_q;
    assign co = co_q;

endmodule

// File: tb/tb_alu_element.sv
// tb/tb_alu_element.sv - directed self-checking bench for alu_element (WIDTH 1, 4, 8)
module tb_alu_element;

    logic       clk;
    logic       reset;
    logic       x, y, w, ci;
    logic       a1, b1, co1, s1;
    logic [3:0] a4, b4, s4;
    logic       co4;
    logic [7:0] a8, b8, s8;
    logic       co8;

    int errors;
    int checks;

    alu_element #(.WIDTH(1)) u_w1 (
        .clk(clk), .reset(reset), .x(x), .y(y), .w(w), .ci(ci),
        .a(a1), .b(b1), .co(co1), .s(s1)
    );

    alu_element #(.WIDTH(4)) u_w4 (
        .clk(clk), .reset(reset), .x(x), .y(y), .w(w), .ci(ci),
        .a(a4), .b(b4), .co(co4), .s(s4)
    );

    alu_element #(.WIDTH(8)) u_w8 (
        .clk(clk), .reset(reset), .x(x), .y(y), .w(w), .ci(ci),
        .a(a8), .b(b8), .co(co8), .s(s8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {co,s}=%h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] op);
        {x, y, w} = op;
    endtask

    // Reference for a WIDTH=1 slice, written from the opcode table using integer arithmetic.
    function automatic logic [1:0] ref1(input logic [2:0] op, input logic c, input logic av, input logic bv);
        int sum;
        case (op)
            3'b000:  return {1'b0, av & bv};
            3'b001:  return {1'b0, av | bv};
            3'b010:  return {1'b0, av ^ bv};
            3'b011:  return {1'b0, ~bv};
            3'b100: begin sum = int'(av) + int'(bv) + int'(c);  return sum[1:0]; end
            3'b101: begin sum = int'(av) + int'(!bv) + int'(c); return sum[1:0]; end
            3'b110: begin sum = int'(av) + int'(c);             return sum[1:0]; end
            default: return 2'b00;
        endcase
    endfunction

    initial begin
        logic [5:0] v;
        logic [1:0] e;
        errors = 0;
        checks = 0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;

        // Reset held two edges with an ADD that would otherwise produce {1,1}.
        reset = 1'b1;
        set_op(3'b100); ci = 1'b1; a1 = 1'b1; b1 = 1'b1;
        tick();
        check("reset_edge1", {7'd0, co1, s1}, 9'd0);
        tick();
        check("reset_edge2", {7'd0, co1, s1}, 9'd0);
        check("reset_w8", {co8, s8}, 9'd0);
        reset = 1'b0;
        tick();
        check("post_reset_add", {7'd0, co1, s1}, {7'd0, 2'b11});

        // Exhaustive WIDTH=1 over ops 000..110.
        for (int i = 0; i < 56; i++) begin
            v = 6'(i);
            {x, y, w, ci, a1, b1} = v;
            e = ref1(v[5:3], v[2], v[1], v[0]);
            tick();
            check($sformatf("w1_vec%0d", i), {7'd0, co1, s1}, {7'd0, e});
        end

        // Hand-picked WIDTH=1 cases.
        set_op(3'b100); ci = 1'b1; a1 = 1'b1; b1 = 1'b0;
        tick();
        check("w1_add_carry", {7'd0, co1, s1}, {7'd0, 2'b10});
        set_op(3'b101); ci = 1'b1; a1 = 1'b0; b1 = 1'b1;
        tick();
        check("w1_sub_borrow", {7'd0, co1, s1}, {7'd0, 2'b01});
        set_op(3'b011); ci = 1'b1; a1 = 1'b1; b1 = 1'b0;
        tick();
        check("w1_not", {7'd0, co1, s1}, {7'd0, 2'b01});

        // Reserved op clears everything regardless of inputs.
        set_op(3'b111);
        for (int i = 0; i < 8; i++) begin
            v = 6'(i);
            {ci, a1, b1} = v[2:0];
            a8 = 8'hFF; b8 = 8'hFF;
            tick();
            check($sformatf("rsvd_w1_%0d", i), {7'd0, co1, s1}, 9'd0);
            check($sformatf("rsvd_w8_%0d", i), {co8, s8}, 9'd0);
        end

        // WIDTH=8 add / subtract.
        set_op(3'b100); ci = 1'b0; a8 = 8'hFF; b8 = 8'h01;
        tick();
        check("w8_add_ovf", {co8, s8}, {1'b1, 8'h00});
        ci = 1'b1; a8 = 8'h12; b8 = 8'h34;
        tick();
        check("w8_add_ci", {co8, s8}, {1'b0, 8'h47});
        set_op(3'b101); ci = 1'b1; a8 = 8'h05; b8 = 8'h07;
        tick();
        check("w8_sub_neg", {co8, s8}, {1'b0, 8'hFE});
        a8 = 8'h07; b8 = 8'h05;
        tick();
        check("w8_sub_pos", {co8, s8}, {1'b1, 8'h02});
        set_op(3'b110); ci = 1'b1; a8 = 8'hFF;
        tick();
        check("w8_inc_wrap", {co8, s8}, {1'b1, 8'h00});
        set_op(3'b000); ci = 1'b1; a8 = 8'hF0; b8 = 8'h3C;
        tick();
        check("w8_and_ignores_ci", {co8, s8}, {1'b0, 8'h30});

        // Back-to-back ops on WIDTH=4, one-cycle latency.
        a4 = 4'b1100; b4 = 4'b1010; ci = 1'b0;
        set_op(3'b000);
        tick();
        check("b2b_and", {co4, 4'd0, s4}, {1'b0, 4'd0, 4'b1000});
        set_op(3'b001);
        #1;
        check("b2b_hold_before_edge", {co4, 4'd0, s4}, {1'b0, 4'd0, 4'b1000});
        tick();
        check("b2b_or", {co4, 4'd0, s4}, {1'b0, 4'd0, 4'b1110});
        set_op(3'b010);
        tick();
        check("b2b_xor", {co4, 4'd0, s4}, {1'b0, 4'd0, 4'b0110});

        // Mid-stream reset: asynchronous assertion must not move outputs, the edge clears them.
        set_op(3'b100); ci = 1'b0; a8 = 8'h80; b8 = 8'h81;
        tick();
        check("pre_reset_add", {co8, s8}, {1'b1, 8'h01});
        a8 = 8'h01; b8 = 8'h01;
        reset = 1'b1;
        #2;
        check("reset_sync_hold", {co8, s8}, {1'b1, 8'h01});
        tick();
        check("reset_midstream", {co8, s8}, 9'd0);
        reset = 1'b0;
        tick();
        check("after_reset_resume", {co8, s8}, {1'b0, 8'h02});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_element.md
Name: alu_element

Overview:
- Registered WIDTH-bit ALU slice. Ripple-chain of 1-bit ALU cells with a shared 3-bit op select (x, y, w), carry-in ci and carry-out co.
- Default WIDTH=1 is the basic 1-bit ALU element. Wider instances or cascades of 1-bit instances build multi-bit ALUs via ci/co.
- Combinational result is captured into output registers on each rising clock edge.

Parameters:
- WIDTH, 1, operand/result width in bits (>=1); carry ripples from bit 0 to bit WIDTH-1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- x  input  1  op select bit 2 (MSB).
- y  input  1  op select bit 1.
- w  input  1  op select bit 0 (LSB).
- ci  input  1  carry-in to bit 0.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- co  output  1  registered carry-out of bit WIDTH-1.
- s  output  WIDTH  registered result.

Behaviour:
- Opcode op = {x,y,w}. Per-bit function for bit i, with carry c_i (c_0 = ci) and c_{i+1} generated by that bit:
  - 000 AND: s_i=a_i&b_i; carries forced 0, co=0.
  - 001 OR: s_i=a_i|b_i; co=0.
  - 010 XOR: s_i=a_i^b_i; co=0.
  - 011 NOT: s_i=~b_i; co=0.
  - 100 ADD: s_i=a_i^b_i^c_i; c_{i+1}=majority(a_i,b_i,c_i); co=c_WIDTH. Result is {co,s}=a+b+ci.
  - 101 SUB: same as ADD with b_i inverted. Result is a+~b+ci. ci=1 gives a-b; co=1 means no borrow.
  - 110 PASS/INC: s_i=a_i^c_i; c_{i+1}=a_i&c_i. Result is a+ci.
  - 111 reserved: s=0, co=0.
- Logic ops (000-011) ignore ci entirely.
- Latency: exactly 1 cycle. Values sampled at rising edge N appear on s/co after edge N, and hold until the next edge.
- No enable and no handshake. A new result is registered every cycle.
- Reset: when reset=1 at a rising edge, s<=0 and co<=0, overriding any operation.
  - Reset is synchronous: the outputs do not change on reset assertion between edges.
  - Reset deasserted at edge N: the result of inputs sampled at edge N+1 appears after edge N+1.
  - Reset asserted mid-stream discards the in-flight result.
- Before the first clock edge, outputs are undefined. The bench applies reset for at least 1 cycle first.
- Arithmetic is modulo 2^WIDTH in s; the overflow bit goes only to co.
- Carry-out is the unsigned carry/not-borrow. No signed overflow flag is provided.
- Cascading: co of slice k drives ci of slice k+1. With registered outputs, a cascade is valid only if the user adds matching pipeline alignment; a single wide instance ripples combinationally within one cycle.

Test Plan:
- Reset: reset=1 for 2 cycles with op=100, a=1, b=1, ci=1 -> s=0, co=0. Deassert; after the next edge -> s=1, co=1.
- Exhaustive WIDTH=1: sweep i=0..55 as {x,y,w,ci,a,b}. Each vector -> table above after 1 cycle.
  - Examples: 100,ci=1,a=1,b=0 -> co=1,s=0.
  - 101,ci=1,a=0,b=1 -> co=0,s=1 (borrow).
  - 011,a=x,b=0 -> s=1,co=0.
- Reserved op: op=111 with all a,b,ci combinations -> s=0, co=0.
- WIDTH=8 ADD overflow: a=8'hFF, b=8'h01, ci=0 -> s=8'h00, co=1. Then a=8'h12, b=8'h34, ci=1 -> s=8'h47, co=0.
- WIDTH=8 SUB: a=8'h05, b=8'h07, ci=1 -> s=8'hFE, co=0. Then a=8'h07, b=8'h05 -> s=8'h02, co=1.
- Latency and back-to-back: change op every cycle (AND, OR, XOR) with a=4'b1100, b=4'b1010 -> outputs follow one cycle later: 1000, 1110, 0110, co=0 throughout.
